clock_mode_controller: RTL and testbench
========================================

Name: clock_mode_controller

Overview:
- Sequences the stopwatch and watch datapaths from the debounced single-cycle button pulses.
- Holds the stopwatch run/stop/clear FSM and the watch time-edit FSM, including an edit-mode inactivity timeout.
- Sits between the button debounce/demux front end and the stopwatch/watch counters.
- All outputs are registered.

Parameters:
- EDIT_TIMEOUT_S, 10: number of tick_1hz pulses with no accepted button press before watch edit mode exits automatically. Legal range 1..255.

Ports:
- clk  input  1  system clock
- reset  input  1  reset, asynchronous, active-high
- sw_mode  input  1  0 = stopwatch mode, 1 = watch mode; asynchronous level, synchronised internally
- tick_1hz  input  1  single-cycle pulse from the timebase, once per second
- btn_run  input  1  debounced single-cycle pulse, stopwatch run/stop
- btn_clear  input  1  debounced pulse, stopwatch clear
- btn_sec  input  1  debounced pulse, watch edit enter / seconds zero
- btn_min  input  1  debounced pulse, watch minute increment
- btn_hour  input  1  debounced pulse, watch hour increment
- sw_run  output  1  level; stopwatch counter enable
- sw_clear  output  1  single-cycle pulse; stopwatch counter clear
- wc_edit  output  1  level; watch in edit mode, watch seconds counting held
- wc_inc_min  output  1  single-cycle pulse; increment watch minutes
- wc_inc_hour  output  1  single-cycle pulse; increment watch hours
- wc_zero_sec  output  1  single-cycle pulse; zero watch seconds
- led_state  output  4  [0] stopwatch RUN, [1] stopwatch STOP, [2] watch NORMAL, [3] watch EDIT

Behaviour:
- Reset values:
  - sw_run=0, sw_clear=0, wc_edit=0, all wc_* pulses 0.
  - led_state=4'b0110.
  - Stopwatch FSM in S_STOP; watch FSM in W_NORMAL; timeout counter 0.
  - Synchroniser flops cleared to 0.
- sw_mode synchronisation:
  - Two-flop synchroniser; mode_s is the synchronised value.
  - All button gating uses mode_s.
- Button gating:
  - btn_run and btn_clear are accepted only when mode_s=0.
  - btn_sec, btn_min and btn_hour are accepted only when mode_s=1.
  - Pulses that are not accepted are dropped, not queued.
- Latency: an accepted pulse in cycle N produces its output change or pulse in cycle N+1.
- Stopwatch FSM (S_STOP, S_RUN, S_CLEAR):
  - S_STOP: btn_run -> S_RUN; else btn_clear -> S_CLEAR. When both arrive in the same cycle, run wins.
  - S_RUN: btn_run -> S_STOP; btn_clear is ignored.
  - S_CLEAR: unconditionally -> S_STOP next cycle. sw_clear=1 for exactly that one cycle.
  - sw_run=1 only in S_RUN.
  - The stopwatch state is independent of mode_s: it keeps running while the watch is displayed.
- Watch FSM (W_NORMAL, W_EDIT):
  - W_NORMAL: btn_sec -> W_EDIT; btn_min and btn_hour are ignored.
  - W_EDIT, priority sec > hour > min, at most one action per cycle:
    - btn_sec -> wc_zero_sec pulse, then -> W_NORMAL.
    - else btn_hour -> wc_inc_hour pulse.
    - else btn_min -> wc_inc_min pulse.
  - W_EDIT, forced exit: mode_s falling to 0 -> W_NORMAL immediately, with no pulse.
  - W_EDIT, timeout: the counter reaches EDIT_TIMEOUT_S -> W_NORMAL, with no pulse.
  - wc_edit=1 only in W_EDIT.
- Timeout counter:
  - 8 bits wide.
  - Cleared on entry to W_EDIT and on any accepted edit button.
  - Increments on tick_1hz while in W_EDIT and saturates.
  - If tick_1hz and an accepted button arrive in the same cycle, the clear wins.
  - Exit occurs in the cycle after the count equals EDIT_TIMEOUT_S.
  - Held at 0 while in W_NORMAL.
- Reset mid-operation: all state returns to reset values immediately; any pending pulse is lost.
- led_state is registered alongside the FSM states; exactly one bit of [1:0] and one bit of [3:2] is set at any time.

Decomposition:
- Package clock_mode_pkg holds:
  - the stopwatch state encoding (S_STOP=2'd0, S_RUN=2'd1, S_CLEAR=2'd2);
  - the watch state encoding (W_NORMAL=1'b0, W_EDIT=1'b1);
  - the EDIT_TIMEOUT_S default.
- One natural sub-module: edit_timeout_counter, with inputs clear, enable and tick, output expired, and parameter EDIT_TIMEOUT_S.
- The two FSMs stay in the top module.

Test Plan:
- Stopwatch start/stop: sw_mode=0; btn_run pulse -> sw_run=1 the next cycle, led_state[0]=1; second btn_run -> sw_run=0.
- Clear and priority:
  - In S_STOP, btn_clear -> sw_clear high for exactly 1 cycle, then S_STOP.
  - In S_RUN, btn_clear -> no sw_clear.
  - btn_run and btn_clear in the same cycle from S_STOP -> S_RUN, with no clear.
- Mode gating: sw_mode=1 with stopwatch in S_RUN; btn_run pulse -> sw_run stays 1; sw_mode back to 0 -> run continues.
- Watch edit:
  - sw_mode=1; btn_sec -> wc_edit=1.
  - btn_hour x3 -> three wc_inc_hour pulses.
  - btn_min and btn_hour in the same cycle -> only wc_inc_hour.
  - btn_sec -> wc_zero_sec pulse, then wc_edit=0.
- Timeout, with EDIT_TIMEOUT_S=3:
  - Enter edit, then 3 tick_1hz pulses -> wc_edit=0 the cycle after the 3rd tick, with no pulses.
  - Repeat with a btn_min pulse after the 2nd tick -> exit only after 3 further ticks.
- Reset and forced exit:
  - In W_EDIT, drop sw_mode to 0 -> wc_edit=0 within 3 cycles.
  - Assert reset in S_RUN -> sw_run=0 and led_state=4'b0110 immediately.

Source files
------------

// File: rtl/clock_mode_controller_pkg.sv
// Shared encodings and defaults for the stopwatch/watch mode controller.
package clock_mode_pkg;

  typedef enum logic [1:0] {
    S_STOP  = 2'd0,
    S_RUN   = 2'd1,
    S_CLEAR = 2'd2
  } sw_state_e;

  typedef enum logic {
    W_NORMAL = 1'b0,
    W_EDIT   = 1'b1
  } wc_state_e;

  localparam int unsigned EDIT_TIMEOUT_S_DEFAULT = 10;

endpackage

// File: rtl/clock_mode_controller_edit_timeout_counter.sv
// Saturating seconds counter that flags when watch edit mode has been idle too long.
module edit_timeout_counter
  import clock_mode_pkg::*;
#(
  parameter int unsigned EDIT_TIMEOUT_S = EDIT_TIMEOUT_S_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  input  logic tick,
  output logic expired
);

  logic [7:0] count_q;
  logic [7:0] count_d;

  // Clear beats tick; dropping enable parks the count at zero.
  always_comb begin
    count_d = count_q;
    if (!enable || clear) begin
      count_d = 8'd0;
    end else if (tick && (count_q != 8'hFF)) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == 8'(EDIT_TIMEOUT_S));

endmodule

// File: rtl/clock_mode_controller.sv
// Stopwatch run/stop/clear FSM and watch time-edit FSM driven by debounced button pulses.
module clock_mode_controller
  import clock_mode_pkg::*;
#(
  parameter int unsigned EDIT_TIMEOUT_S = EDIT_TIMEOUT_S_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sw_mode,
  input  logic       tick_1hz,
  input  logic       btn_run,
  input  logic       btn_clear,
  input  logic       btn_sec,
  input  logic       btn_min,
  input  logic       btn_hour,
  output logic       sw_run,
  output logic       sw_clear,
  output logic       wc_edit,
  output logic       wc_inc_min,
  output logic       wc_inc_hour,
  output logic       wc_zero_sec,
  output logic [3:0] led_state
);

  logic      sync1_q;
  logic      mode_s;
  sw_state_e sw_state_q;
  wc_state_e wc_state_q;
  logic      sw_run_q, sw_clear_q;
  logic      wc_edit_q, wc_inc_min_q, wc_inc_hour_q, wc_zero_sec_q;
  logic [1:0] led_sw_q, led_wc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      mode_s  <= 1'b0;
    end else begin
      sync1_q <= sw_mode;
      mode_s  <= sync1_q;
    end
  end

  logic run_acc, clr_acc, sec_acc, min_acc, hour_acc, edit_btn;
  assign run_acc  = btn_run   & ~mode_s;
  assign clr_acc  = btn_clear & ~mode_s;
  assign sec_acc  = btn_sec   &  mode_s;
  assign min_acc  = btn_min   &  mode_s;
  assign hour_acc = btn_hour  &  mode_s;
  assign edit_btn = sec_acc | min_acc | hour_acc;

  logic in_edit, edit_enter, edit_exit, expired, timer_clear, timer_enable;
  assign in_edit    = (wc_state_q == W_EDIT);
  assign edit_enter = ~in_edit & sec_acc;
  // A button press in the same cycle as expiry keeps edit mode alive.
  assign edit_exit  = in_edit & (~mode_s | sec_acc | (expired & ~edit_btn));
  assign timer_clear  = edit_enter | (in_edit & edit_btn);
  assign timer_enable = edit_enter | (in_edit & ~edit_exit);

  edit_timeout_counter #(
    .EDIT_TIMEOUT_S(EDIT_TIMEOUT_S)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .enable (timer_enable),
    .tick   (tick_1hz),
    .expired(expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_state_q <= S_STOP;
      sw_run_q   <= 1'b0;
      sw_clear_q <= 1'b0;
      led_sw_q   <= 2'b10;
    end else begin
      sw_clear_q <= 1'b0;
      case (sw_state_q)
        S_STOP: begin
          if (run_acc) begin
            sw_state_q <= S_RUN;
            sw_run_q   <= 1'b1;
            led_sw_q   <= 2'b01;
          end else if (clr_acc) begin
            sw_state_q <= S_CLEAR;
            sw_clear_q <= 1'b1;
          end
        end
        S_RUN: begin
          if (run_acc) begin
            sw_state_q <= S_STOP;
            sw_run_q   <= 1'b0;
            led_sw_q   <= 2'b10;
          end
        end
        default: begin
          sw_state_q <= S_STOP;
          sw_run_q   <= 1'b0;
          led_sw_q   <= 2'b10;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wc_state_q    <= W_NORMAL;
      wc_edit_q     <= 1'b0;
      wc_inc_min_q  <= 1'b0;
      wc_inc_hour_q <= 1'b0;
      wc_zero_sec_q <= 1'b0;
      led_wc_q      <= 2'b01;
    end else begin
      wc_inc_min_q  <= 1'b0;
      wc_inc_hour_q <= 1'b0;
      wc_zero_sec_q <= 1'b0;
      case (wc_state_q)
        W_NORMAL: begin
          if (sec_acc) begin
            wc_state_q <= W_EDIT;
            wc_edit_q  <= 1'b1;
            led_wc_q   <= 2'b10;
          end
        end
        default: begin
          if (edit_exit) begin
            wc_state_q    <= W_NORMAL;
            wc_edit_q     <= 1'b0;
            led_wc_q      <= 2'b01;
            wc_zero_sec_q <= sec_acc;
          end else begin
            wc_inc_hour_q <= hour_acc;
            wc_inc_min_q  <= min_acc & ~hour_acc;
          end
        end
      endcase
    end
  end

  assign sw_run      = sw_run_q;
  assign sw_clear    = sw_clear_q;
  assign wc_edit     = wc_edit_q;
  assign wc_inc_min  = wc_inc_min_q;
  assign wc_inc_hour = wc_inc_hour_q;
  assign wc_zero_sec = wc_zero_sec_q;
  assign led_state   = {led_wc_q, led_sw_q};

endmodule

// File: tb/tb_clock_mode_controller.sv
// Directed and random stimulus for clock_mode_controller, checked every cycle against a behavioural model.
module tb_clock_mode_controller;

  localparam int T = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sw_mode = 1'b0, tick_1hz = 1'b0;
  logic btn_run = 1'b0, btn_clear = 1'b0, btn_sec = 1'b0, btn_min = 1'b0, btn_hour = 1'b0;
  logic sw_run, sw_clear, wc_edit, wc_inc_min, wc_inc_hour, wc_zero_sec;
  logic [3:0] led_state;

  int checks = 0;
  int failures = 0;

  // Model: what the user sees, not how the RTL encodes it.
  bit m_running, m_clearing, m_edit;
  bit m_zero, m_inch, m_incm;
  bit m_s1, m_s2;
  int m_idle_secs;

  always #5 clk = ~clk;

  clock_mode_controller #(.EDIT_TIMEOUT_S(T)) dut (
    .clk(clk), .reset(reset), .sw_mode(sw_mode), .tick_1hz(tick_1hz),
    .btn_run(btn_run), .btn_clear(btn_clear), .btn_sec(btn_sec),
    .btn_min(btn_min), .btn_hour(btn_hour),
    .sw_run(sw_run), .sw_clear(sw_clear), .wc_edit(wc_edit),
    .wc_inc_min(wc_inc_min), .wc_inc_hour(wc_inc_hour), .wc_zero_sec(wc_zero_sec),
    .led_state(led_state)
  );

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic check_all();
    check_eq("sw_run",   {7'd0, sw_run},   {7'd0, m_running});
    check_eq("sw_clear", {7'd0, sw_clear}, {7'd0, m_clearing});
    check_eq("wc_edit",  {7'd0, wc_edit},  {7'd0, m_edit});
    check_eq("wc_pulses", {5'd0, wc_zero_sec, wc_inc_hour, wc_inc_min}, {5'd0, m_zero, m_inch, m_incm});
    check_eq("led_state", {4'd0, led_state}, {4'd0, m_edit, !m_edit, !m_running, m_running});
  endtask

  task automatic model_reset();
    m_running = 0; m_clearing = 0; m_edit = 0;
    m_zero = 0; m_inch = 0; m_incm = 0;
    m_s1 = 0; m_s2 = 0; m_idle_secs = 0;
  endtask

  task automatic model_step();
    bit ms, a_run, a_clr, a_sec, a_min, a_hour;
    ms     = m_s2;
    a_run  = btn_run   && !ms;
    a_clr  = btn_clear && !ms;
    a_sec  = btn_sec   && ms;
    a_min  = btn_min   && ms;
    a_hour = btn_hour  && ms;

    if (m_clearing) begin
      m_clearing = 0;
    end else if (m_running) begin
      if (a_run) m_running = 0;
    end else if (a_run) begin
      m_running = 1;
    end else if (a_clr) begin
      m_clearing = 1;
    end

    m_zero = 0; m_inch = 0; m_incm = 0;
    if (!m_edit) begin
      if (a_sec) m_edit = 1;
      m_idle_secs = 0;
    end else if (!ms) begin
      m_edit = 0; m_idle_secs = 0;
    end else if (a_sec) begin
      m_zero = 1; m_edit = 0; m_idle_secs = 0;
    end else if (a_hour) begin
      m_inch = 1; m_idle_secs = 0;
    end else if (a_min) begin
      m_incm = 1; m_idle_secs = 0;
    end else if (m_idle_secs == T) begin
      m_edit = 0; m_idle_secs = 0;
    end else if (tick_1hz) begin
      m_idle_secs = (m_idle_secs < 255) ? m_idle_secs + 1 : 255;
    end

    m_s2 = m_s1;
    m_s1 = sw_mode;
  endtask

  // Drive one cycle of inputs, advance the model, then check after the edge.
  task automatic cycle(input bit md, input bit run, input bit clr, input bit sec,
                       input bit mn, input bit hr, input bit tk);
    sw_mode = md; btn_run = run; btn_clear = clr; btn_sec = sec;
    btn_min = mn; btn_hour = hr; tick_1hz = tk;
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input bit md, input int n);
    for (int i = 0; i < n; i++) cycle(md, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check_eq("rst_sw_run", {7'd0, sw_run}, 8'd0);
    check_eq("rst_led", {4'd0, led_state}, 8'h06);
    check_eq("rst_wc_edit", {7'd0, wc_edit}, 8'd0);
    model_reset();
    @(negedge clk);
    check_all();
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    check_all();
    reset = 1'b0;

    // Stopwatch start/stop, clear, clear ignored while running, run beats clear.
    idle(0, 2);
    cycle(0, 1, 0, 0, 0, 0, 0); idle(0, 2);
    cycle(0, 1, 0, 0, 0, 0, 0); idle(0, 1);
    cycle(0, 0, 1, 0, 0, 0, 0); idle(0, 2);
    cycle(0, 1, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 0, 0); idle(0, 1);
    cycle(0, 1, 0, 0, 0, 0, 0); idle(0, 1);
    cycle(0, 1, 1, 0, 0, 0, 0); idle(0, 2);

    // Stopwatch keeps running in watch mode and ignores btn_run there.
    idle(1, 3);
    cycle(1, 1, 0, 0, 0, 0, 0); idle(1, 1);
    idle(0, 3);
    cycle(0, 1, 0, 0, 0, 0, 0);

    // Watch edit: enter, hour x3, min+hour, zero seconds.
    idle(1, 3);
    cycle(1, 0, 0, 1, 0, 0, 0); idle(1, 1);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 0, 0, 0, 1, 0); idle(1, 1);
    end
    cycle(1, 0, 0, 0, 1, 1, 0); idle(1, 1);
    cycle(1, 0, 0, 1, 0, 0, 0); idle(1, 2);

    // Timeout after T ticks, then restarted by btn_min after the 2nd tick.
    cycle(1, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < T; i++) begin
      cycle(1, 0, 0, 0, 0, 0, 1); idle(1, 1);
    end
    idle(1, 2);
    cycle(1, 0, 0, 1, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 1); cycle(1, 0, 0, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < T; i++) begin
      cycle(1, 0, 0, 0, 0, 0, 1); idle(1, 1);
    end
    idle(1, 2);

    // Forced exit on leaving watch mode, then reset while running.
    cycle(1, 0, 0, 1, 0, 0, 0); idle(1, 1);
    idle(0, 4);
    cycle(0, 1, 0, 0, 0, 0, 0); idle(0, 1);
    do_reset();

    // Random traffic with occasional mode flips and resets.
    begin
      bit md;
      md = 0;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(0, 39) == 0) md = ~md;
        if ($urandom_range(0, 599) == 0) begin
          do_reset();
        end else begin
          cycle(md, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
